// File: rtl/alu_pkg.sv
// alu_pkg: shared state encoding, opcode width, flag bit positions and key roles
package alu_pkg;
    typedef enum logic [2:0] {
        S_A    = 3'd0,
        S_B    = 3'd1,
        S_OP   = 3'd2,
        S_EXEC = 3'd3,
        S_CAP  = 3'd4,
        S_SHOW = 3'd5
    } state_t;
    localparam int OPCODE_W    = 4;
    localparam int FLAG_N      = 3;
    localparam int FLAG_Z      = 2;
    localparam int FLAG_C      = 1;
    localparam int FLAG_V      = 0;
    localparam int KEY_CONFIRM = 0;
    localparam int KEY_CLEAR   = 3;
endpackage

// File: rtl/key_debounce.sv
// key_debounce: 2-FF synchronizer, level debouncer and press pulse for one active-low key
// Ports: clk, rst (sync, active-high), key_n (raw pin, pressed = 0), press (one-cycle pulse on accepted press)
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic press
);
    localparam int CW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
    logic          sync1_q, sync2_q, level_q, level_d;
    logic [CW-1:0] cnt_q, cnt_d;
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) level_d = sync2_q;
            else cnt_d = cnt_q + CW'(1);
        end
    end
    // Pulse in the cycle the accepted level falls, so the FSM acts on the same edge as the flip
    assign press = level_q & ~level_d;
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            cnt_q   <= '0;
        end else begin
            sync1_q <= key_n;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: rtl/alu_operand_sequencer.sv
// alu_operand_sequencer: debounced key entry of A, B and opcode, ALU strobe, and result/flag capture
// Ports: clk, rst (sync, active-high), key (active-low buttons), sw (entry switches),
//        alu_result/alu_flags (from ALU), a/b/opcode/alu_valid (to ALU),
//        disp_value/disp_flags (to displays), stage (state for LEDs)
module alu_operand_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [3:0]          key,
    input  logic [9:0]          sw,
    input  logic [WIDTH-1:0]    alu_result,
    input  logic [3:0]          alu_flags,
    output logic [WIDTH-1:0]    a,
    output logic [WIDTH-1:0]    b,
    output logic [OPCODE_W-1:0] opcode,
    output logic                alu_valid,
    output logic [WIDTH-1:0]    disp_value,
    output logic [3:0]          disp_flags,
    output logic [2:0]          stage
);
    logic [3:0]          press;
    logic                unused_bits;
    state_t              state_q, state_d;
    logic [WIDTH-1:0]    a_q, a_d, b_q, b_d, dv_q, dv_d;
    logic [OPCODE_W-1:0] op_q, op_d;
    logic [3:0]          df_q, df_d;
    for (genvar k = 0; k < 4; k++) begin : g_key
        key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk  (clk),
            .rst  (rst),
            .key_n(key[k]),
            .press(press[k])
        );
    end
    // Keys 1 and 2 are debounced for future use; upper switches are not part of the entry field
    assign unused_bits = ^{press[2:1], sw};
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        dv_d    = dv_q;
        df_d    = df_q;
        case (state_q)
            S_A, S_B, S_OP: begin
                dv_d = sw[WIDTH-1:0];
                df_d = '0;
                if (press[KEY_CONFIRM]) begin
                    a_d     = state_q == S_A  ? sw[WIDTH-1:0] : a_q;
                    b_d     = state_q == S_B  ? sw[WIDTH-1:0] : b_q;
                    op_d    = state_q == S_OP ? sw[OPCODE_W-1:0] : op_q;
                    state_d = state_q == S_A ? S_B : state_q == S_B ? S_OP : S_EXEC;
                end
            end
            S_EXEC: state_d = S_CAP;
            S_CAP: begin
                dv_d    = alu_result;
                df_d    = alu_flags;
                state_d = S_SHOW;
            end
            S_SHOW: state_d = press[KEY_CONFIRM] ? S_A : S_SHOW;
            default: state_d = S_A;
        endcase
        // Clear overrides any confirm seen in the same cycle
        if (press[KEY_CLEAR]) begin
            state_d = S_A;
            a_d     = '0;
            b_d     = '0;
            op_d    = '0;
            dv_d    = '0;
            df_d    = '0;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_A;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            dv_q    <= '0;
            df_q    <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            dv_q    <= dv_d;
            df_q    <= df_d;
        end
    end
    assign a          = a_q;
    assign b          = b_q;
    assign opcode     = op_q;
    assign alu_valid  = state_q == S_EXEC;
    assign disp_value = dv_q;
    assign disp_flags = df_q;
    assign stage      = state_q;
endmodule

// File: tb/tb_alu_operand_sequencer.sv
// tb_alu_operand_sequencer: directed vectors against a small ADD-only ALU model
module tb_alu_operand_sequencer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] key = 4'hF;
    logic [9:0] sw = '0;
    logic [3:0] alu_result, alu_flags, a, b, opcode, disp_value, disp_flags;
    logic       alu_valid;
    logic [2:0] stage;
    logic [4:0] sum;
    logic       saw_valid;
    int         vecs = 0;
    int         errs = 0;
    alu_operand_sequencer #(.WIDTH(4), .DEBOUNCE_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .key(key), .sw(sw),
        .alu_result(alu_result), .alu_flags(alu_flags),
        .a(a), .b(b), .opcode(opcode), .alu_valid(alu_valid),
        .disp_value(disp_value), .disp_flags(disp_flags), .stage(stage)
    );
    always #5 clk = ~clk;
    // Opcode 1 is ADD; flags {N,Z,C,V}
    assign sum        = {1'b0, a} + {1'b0, b};
    assign alu_result = opcode == 4'h1 ? sum[3:0] : 4'h0;
    assign alu_flags  = {alu_result[3], alu_result == 4'h0, opcode == 4'h1 && sum[4],
                         opcode == 4'h1 && a[3] == b[3] && alu_result[3] != a[3]};
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic press(input int k);
        key[k] = 1'b0;
        tick(8);
        key[k] = 1'b1;
        tick(8);
    endtask
    initial begin
        tick(2);
        rst = 1'b0;
        tick(1);
        check("rst_a", a, 0);
        check("rst_b", b, 0);
        check("rst_op", opcode, 0);
        check("rst_valid", alu_valid, 0);
        check("rst_dv", disp_value, 0);
        check("rst_df", disp_flags, 0);
        check("rst_stage", stage, 0);
        key[0] = 1'b0;
        tick(5);
        check("lat_t5", stage, 0);
        tick(1);
        check("lat_t6", stage, 1);
        tick(4);
        check("hold_once", stage, 1);
        key[0] = 1'b1;
        tick(8);
        check("release_noevt", stage, 1);
        press(3);
        check("clear_stage", stage, 0);
        for (int i = 0; i < 10; i++) begin
            key[0] = i[0];
            tick(2);
        end
        key[0] = 1'b1;
        tick(8);
        check("bounce_stage", stage, 0);
        sw = 10'd3;
        press(0);
        check("seq_stage1", stage, 1);
        check("seq_a", a, 3);
        sw = 10'hA;
        tick(1);
        check("echo_dv", disp_value, 4'hA);
        check("echo_df", disp_flags, 0);
        sw = 10'd5;
        press(0);
        check("seq_stage2", stage, 2);
        check("seq_b", b, 5);
        sw = 10'd1;
        key[0] = 1'b0;
        tick(5);
        check("pre_exec_valid", alu_valid, 0);
        tick(1);
        check("exec_stage", stage, 3);
        check("exec_valid", alu_valid, 1);
        check("exec_a", a, 3);
        check("exec_b", b, 5);
        check("exec_op", opcode, 1);
        tick(1);
        check("cap_stage", stage, 4);
        check("cap_valid", alu_valid, 0);
        tick(1);
        check("show_stage", stage, 5);
        check("show_dv", disp_value, 8);
        check("show_df", disp_flags, 4'b1001);
        key[0] = 1'b1;
        sw = 10'd7;
        tick(10);
        check("show_hold_stage", stage, 5);
        check("show_hold_dv", disp_value, 8);
        press(0);
        check("reenter_stage", stage, 0);
        check("reenter_keep_a", a, 3);
        press(0);
        sw = 10'd2;
        press(0);
        check("both_pre_stage", stage, 2);
        key[0] = 1'b0;
        key[3] = 1'b0;
        saw_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            saw_valid |= alu_valid;
        end
        check("both_stage", stage, 0);
        check("both_a", a, 0);
        check("both_b", b, 0);
        check("both_op", opcode, 0);
        check("both_no_valid", saw_valid, 0);
        key = 4'hF;
        tick(8);
        sw = 10'd1;
        press(0);
        press(0);
        key[0] = 1'b0;
        tick(6);
        check("rst_exec_stage", stage, 3);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("rst_exec_valid", alu_valid, 0);
        check("rst_exec_stage0", stage, 0);
        check("rst_exec_a", a, 0);
        check("rst_exec_op", opcode, 0);
        check("rst_exec_dv", disp_value, 0);
        key[0] = 1'b1;
        tick(8);
        check("post_rst_idle", stage, 0);
        sw = 10'd9;
        press(0);
        check("post_rst_stage", stage, 1);
        check("post_rst_a", a, 9);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
